// File: rtl/gc_pkg.sv
// Shared types and constants for the garbled-circuit gate sequencer and its engine.
package gc_pkg;

    localparam int GC_S = 20;
    localparam int GC_K = 128;

    localparam logic GATE_XOR = 1'b0;
    localparam logic GATE_AND = 1'b1;

    typedef enum logic [2:0] {
        GCS_IDLE  = 3'd0,
        GCS_FETCH = 3'd1,
        GCS_READ  = 3'd2,
        GCS_EVAL  = 3'd3,
        GCS_EMIT  = 3'd4,
        GCS_DONE  = 3'd5
    } gcs_state_t;

endpackage

// File: rtl/gc_label_ram.sv
// Wire label store: one write port, two synchronous read ports.
import gc_pkg::*;

module gc_label_ram #(
    parameter int K  = GC_K,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [K-1:0]  wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [K-1:0]  rdata0,
    output logic [K-1:0]  rdata1
);

    logic [K-1:0] mem [0:(1<<AW)-1];

    // Array contents survive reset; only the read registers are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            rdata0 <= mem[raddr0];
            rdata1 <= mem[raddr1];
        end
    end

endmodule

// File: rtl/gc_gate_sequencer.sv
// Feeds gate descriptors to the AND-gate garbling engine, garbles XOR gates
// locally and writes every output label back to the label RAM.
//
// state | meaning
// IDLE  | host owns the label RAM, waiting for start
// FETCH | accepting a gate descriptor, RAM reads of a/b issued
// READ  | capturing input labels into eng_in0/eng_in1
// EVAL  | writing result to RAM[c]; AND gates load the table row
// EMIT  | holding the table row until tab_ready
// DONE  | one-cycle done pulse
import gc_pkg::*;

module gc_gate_sequencer #(
    parameter int S  = GC_S,
    parameter int K  = GC_K,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [S-1:0]  cid,
    input  logic [S-1:0]  num_gates,
    output logic          busy,
    output logic          done,
    input  logic          gate_valid,
    output logic          gate_ready,
    input  logic          gate_and,
    input  logic [AW-1:0] gate_a,
    input  logic [AW-1:0] gate_b,
    input  logic [AW-1:0] gate_c,
    output logic [S-1:0]  eng_cid,
    output logic [S-1:0]  eng_gid,
    output logic [K-1:0]  eng_in0,
    output logic [K-1:0]  eng_in1,
    input  logic [K-1:0]  eng_t0,
    input  logic [K-1:0]  eng_t1,
    input  logic [K-1:0]  eng_out,
    output logic          tab_valid,
    input  logic          tab_ready,
    output logic [K-1:0]  tab_t0,
    output logic [K-1:0]  tab_t1,
    output logic [S-1:0]  tab_gid,
    input  logic          lbl_we,
    input  logic [AW-1:0] lbl_addr,
    input  logic [K-1:0]  lbl_wdata,
    output logic [K-1:0]  lbl_rdata
);

    gcs_state_t     state;
    logic [S-1:0]   num_q;
    logic [S-1:0]   gid_cnt;
    logic           and_q;
    logic [AW-1:0]  c_q;
    logic           last_gate;
    logic [K-1:0]   result;

    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [K-1:0]   ram_wdata;
    logic [AW-1:0]  ram_raddr0;
    logic [K-1:0]   ram_rdata0;
    logic [K-1:0]   ram_rdata1;

    assign busy       = (state != GCS_IDLE) && (state != GCS_DONE);
    assign done       = (state == GCS_DONE);
    assign gate_ready = (state == GCS_FETCH);
    assign last_gate  = (gid_cnt == num_q - S'(1));
    assign result     = (and_q == GATE_AND) ? eng_out : (eng_in0 ^ eng_in1);
    assign lbl_rdata  = ram_rdata0;

    // Host traffic only reaches the RAM in IDLE; while busy it is dropped.
    always_comb begin
        ram_we     = 1'b0;
        ram_waddr  = lbl_addr;
        ram_wdata  = lbl_wdata;
        ram_raddr0 = gate_a;
        if (state == GCS_IDLE) begin
            ram_we     = lbl_we;
            ram_raddr0 = lbl_addr;
        end else if (state == GCS_EVAL) begin
            ram_we    = 1'b1;
            ram_waddr = c_q;
            ram_wdata = result;
        end
    end

    gc_label_ram #(
        .K  (K),
        .AW (AW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr0 (ram_raddr0),
        .raddr1 (gate_b),
        .rdata0 (ram_rdata0),
        .rdata1 (ram_rdata1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GCS_IDLE;
            num_q     <= '0;
            gid_cnt   <= '0;
            and_q     <= GATE_XOR;
            c_q       <= '0;
            eng_cid   <= '0;
            eng_gid   <= '0;
            eng_in0   <= '0;
            eng_in1   <= '0;
            tab_valid <= 1'b0;
            tab_t0    <= '0;
            tab_t1    <= '0;
            tab_gid   <= '0;
        end else begin
            case (state)
                GCS_IDLE: begin
                    if (start) begin
                        eng_cid <= cid;
                        num_q   <= num_gates;
                        gid_cnt <= '0;
                        state   <= (num_gates == '0) ? GCS_DONE : GCS_FETCH;
                    end
                end
                GCS_FETCH: begin
                    if (gate_valid) begin
                        and_q <= gate_and;
                        c_q   <= gate_c;
                        state <= GCS_READ;
                    end
                end
                GCS_READ: begin
                    eng_in0 <= ram_rdata0;
                    eng_in1 <= ram_rdata1;
                    eng_gid <= gid_cnt;
                    state   <= GCS_EVAL;
                end
                GCS_EVAL: begin
                    if (and_q == GATE_AND) begin
                        tab_t0    <= eng_t0;
                        tab_t1    <= eng_t1;
                        tab_gid   <= gid_cnt;
                        tab_valid <= 1'b1;
                        state     <= GCS_EMIT;
                    end else if (last_gate) begin
                        state <= GCS_DONE;
                    end else begin
                        gid_cnt <= gid_cnt + S'(1);
                        state   <= GCS_FETCH;
                    end
                end
                GCS_EMIT: begin
                    if (tab_ready) begin
                        tab_valid <= 1'b0;
                        if (last_gate) begin
                            state <= GCS_DONE;
                        end else begin
                            gid_cnt <= gid_cnt + S'(1);
                            state   <= GCS_FETCH;
                        end
                    end
                end
                GCS_DONE: state <= GCS_IDLE;
                default:  state <= GCS_IDLE;
            endcase
        end
    end

endmodule
